// File: rtl/demux_pkg.sv
// Shared types and default sizing for the 1:2 stream demultiplexer.
package demux_pkg;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 2;

  typedef logic [DATA_W-1:0] word_t;
  typedef logic              sel_t;
endpackage

// File: rtl/demux_fifo.sv
// Synchronous FIFO with registered head; pointers carry an extra wrap bit for full/empty.
module demux_fifo #(
  parameter int DATA_W = demux_pkg::DATA_W,
  parameter int DEPTH  = demux_pkg::DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic              full,
  output logic              empty,
  output logic [DATA_W-1:0] head
);
  import demux_pkg::*;

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              do_push;
  logic              do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr[AW-1:0]];

  // Storage is cleared too so both outputs present zero data out of reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= push_data;
        wr_ptr              <= wr_ptr + PTR_ONE;
      end
      if (do_pop) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end
endmodule

// File: rtl/demux_1x2_stream.sv
// 1:2 stream demux: each source word is steered by s_sel into one of two per-output FIFOs.
// Optional delivered-word counters cnt0/cnt1 are built when DEMUX_STATS_EN is defined.
module demux_1x2_stream #(
  parameter int DATA_W = demux_pkg::DATA_W,
  parameter int DEPTH  = demux_pkg::DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic              s_sel,
  input  logic [DATA_W-1:0] s_data,
  output logic              o0_valid,
  input  logic              o0_ready,
  output logic [DATA_W-1:0] o0_data,
  output logic              o1_valid,
  input  logic              o1_ready,
  output logic [DATA_W-1:0] o1_data
`ifdef DEMUX_STATS_EN
  ,
  output logic [15:0]       cnt0,
  output logic [15:0]       cnt1
`endif
);
  import demux_pkg::*;

  logic full0, full1, empty0, empty1;
  logic push0, push1, pop0, pop1;
  logic accept;

  // Readiness depends only on the selected FIFO, never on a same-cycle pop.
  assign s_ready  = s_sel ? !full1 : !full0;
  assign accept   = s_valid && s_ready;
  assign push0    = accept && (s_sel == 1'b0);
  assign push1    = accept && (s_sel == 1'b1);
  assign o0_valid = !empty0;
  assign o1_valid = !empty1;
  assign pop0     = o0_valid && o0_ready;
  assign pop1     = o1_valid && o1_ready;

  demux_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo0 (
    .clk       (clk),
    .reset     (reset),
    .push      (push0),
    .push_data (s_data),
    .pop       (pop0),
    .full      (full0),
    .empty     (empty0),
    .head      (o0_data)
  );

  demux_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo1 (
    .clk       (clk),
    .reset     (reset),
    .push      (push1),
    .push_data (s_data),
    .pop       (pop1),
    .full      (full1),
    .empty     (empty1),
    .head      (o1_data)
  );

`ifdef DEMUX_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt0 <= '0;
      cnt1 <= '0;
    end else begin
      if (pop0 && (cnt0 != 16'hFFFF)) cnt0 <= cnt0 + 16'd1;
      if (pop1 && (cnt1 != 16'hFFFF)) cnt1 <= cnt1 + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_demux_1x2_stream.sv
// Scoreboard bench for demux_1x2_stream: driver records accepted words per output,
// an independent negedge monitor compares every presented output against the queues.
module tb_demux_1x2_stream;
  import demux_pkg::*;

  localparam int DEPTH_TB = 2;

  logic  clk = 1'b0;
  logic  reset;
  logic  s_valid;
  logic  s_ready;
  sel_t  s_sel;
  word_t s_data;
  logic  o0_valid, o0_ready;
  word_t o0_data;
  logic  o1_valid, o1_ready;
  word_t o1_data;
`ifdef DEMUX_STATS_EN
  logic [15:0] cnt0, cnt1;
`endif

  demux_1x2_stream #(.DATA_W(16), .DEPTH(DEPTH_TB)) dut (
    .clk      (clk),
    .reset    (reset),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_sel    (s_sel),
    .s_data   (s_data),
    .o0_valid (o0_valid),
    .o0_ready (o0_ready),
    .o0_data  (o0_data),
    .o1_valid (o1_valid),
    .o1_ready (o1_ready),
    .o1_data  (o1_data)
`ifdef DEMUX_STATS_EN
    ,
    .cnt0     (cnt0),
    .cnt1     (cnt1)
`endif
  );

  always #5 clk = ~clk;

  word_t q0[$];
  word_t q1[$];
  int    cnt_m0 = 0;
  int    cnt_m1 = 0;
  int    checks = 0;
  int    errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus; the expected word is enqueued only once the edge has accepted it.
  task automatic step(input logic v, input sel_t sel, input word_t d,
                      input logic r0, input logic r1, input logic rst);
    logic acc;
    reset = rst; s_valid = v; s_sel = sel; s_data = d; o0_ready = r0; o1_ready = r1;
    @(negedge clk);
    acc = v && s_ready && !rst;
    @(posedge clk);
    #1;
    if (rst) begin
      q0.delete(); q1.delete();
      cnt_m0 = 0; cnt_m1 = 0;
    end else if (acc) begin
      if (sel) q1.push_back(d);
      else     q0.push_back(d);
    end
  endtask

  // Monitor: valid must mirror model occupancy, head must match, full blocks regardless of pop.
  always @(negedge clk) begin
    if (!reset) begin
      chk("s_ready", {31'd0, s_ready}, {31'd0, (s_sel ? q1.size() : q0.size()) < DEPTH_TB});
      chk("o0_valid", {31'd0, o0_valid}, {31'd0, q0.size() != 0});
      chk("o1_valid", {31'd0, o1_valid}, {31'd0, q1.size() != 0});
`ifdef DEMUX_STATS_EN
      chk("cnt0", {16'd0, cnt0}, cnt_m0);
      chk("cnt1", {16'd0, cnt1}, cnt_m1);
`endif
      if (o0_valid && q0.size() != 0) begin
        chk("o0_data", {16'd0, o0_data}, {16'd0, q0[0]});
        if (o0_ready) begin
          void'(q0.pop_front());
          if (cnt_m0 < 65535) cnt_m0++;
        end
      end
      if (o1_valid && q1.size() != 0) begin
        chk("o1_data", {16'd0, o1_data}, {16'd0, q1[0]});
        if (o1_ready) begin
          void'(q1.pop_front());
          if (cnt_m1 < 65535) cnt_m1++;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; s_valid = 1'b0; s_sel = 1'b0; s_data = '0; o0_ready = 1'b0; o1_ready = 1'b0;
    @(posedge clk);
    #1;
    step(0, 0, 16'h0, 0, 0, 1);
    step(0, 0, 16'h0, 0, 0, 1);
    chk("rst_o0_data", {16'd0, o0_data}, 32'd0);
    chk("rst_o1_data", {16'd0, o1_data}, 32'd0);

    // Steering with latency 1
    step(1, 0, 16'hA5A5, 1, 1, 0);
    chk("steer_o0_valid", {31'd0, o0_valid}, 32'd1);
    chk("steer_o0_data", {16'd0, o0_data}, 32'h0000A5A5);
    chk("steer_o1_idle", {31'd0, o1_valid}, 32'd0);
    step(1, 1, 16'h5A5A, 1, 1, 0);
    chk("steer_o1_data", {16'd0, o1_data}, 32'h00005A5A);
    step(0, 0, 16'h0, 1, 1, 0);
    step(0, 0, 16'h0, 1, 1, 0);

    // Back-pressure on output 0; output 1 still flows
    step(1, 0, 16'h1111, 0, 1, 0);
    step(1, 0, 16'h2222, 0, 1, 0);
    step(1, 0, 16'h3333, 0, 1, 0);
    chk("bp_sel0_blocked", {31'd0, s_ready}, 32'd0);
    step(1, 1, 16'h4444, 0, 1, 0);
    chk("bp_sel1_accepted", {31'd0, o1_valid}, 32'd1);
    for (int i = 0; i < 3; i++) step(0, 0, 16'h0, 1, 1, 0);

    // Stalled output 1 holds its data
    step(1, 1, 16'hBEEF, 1, 0, 0);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 16'h0, 1, 0, 0);
      chk("stall_o1_data", {16'd0, o1_data}, 32'h0000BEEF);
    end
    step(0, 0, 16'h0, 1, 1, 0);

    // Concurrent push and pop on output 0 with one resident entry
    step(1, 0, 16'h7000, 0, 1, 0);
    for (int i = 1; i <= 10; i++) step(1, 0, word_t'(16'h7000 + i), 1, 1, 0);
    for (int i = 0; i < 2; i++) step(0, 0, 16'h0, 1, 1, 0);

    // Reset with both FIFOs holding data
    for (int i = 0; i < 4; i++) step(1, sel_t'(i & 1), word_t'(16'hC000 + i), 0, 0, 0);
    step(0, 0, 16'h0, 1, 1, 1);
    chk("rst_mid_o0_valid", {31'd0, o0_valid}, 32'd0);
    chk("rst_mid_o1_valid", {31'd0, o1_valid}, 32'd0);
    chk("rst_mid_s_ready", {31'd0, s_ready}, 32'd1);
    step(0, 0, 16'h0, 1, 1, 0);

    // Randomised traffic with occasional reset
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(3) != 0), sel_t'($urandom_range(1)), word_t'($urandom),
           ($urandom_range(2) != 0), ($urandom_range(3) == 0 ? 1'b0 : 1'b1),
           ($urandom_range(199) == 0));
    end
    for (int i = 0; i < 4; i++) step(0, 0, 16'h0, 1, 1, 0);

`ifdef DEMUX_STATS_EN
    step(0, 0, 16'h0, 1, 1, 1);
    for (int i = 0; i < 70002; i++) step(1, 0, word_t'(i), 1, 1, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 16'h0, 1, 1, 0);
    chk("stats_cnt0_sat", {16'd0, cnt0}, 32'h0000FFFF);
    chk("stats_cnt1", {16'd0, cnt1}, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
